// File: rtl/mem_pkg.sv
// Shared memory-stage types and widths used by the data-memory responder and its RAM.
package mem_pkg;

    localparam int unsigned DATA_W    = 18;
    localparam int unsigned PC_W      = 9;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_BUSY,
        MS_RESP
    } mem_state_t;

endpackage

// File: rtl/data_ram_sp.sv
// Single-port synchronous RAM: write enable, registered read, no reset on the array.
module data_ram_sp #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data-access responder: services load/store requests against an internal RAM
// with fixed read/write latency, stalling the M stage until the one-cycle response.
module data_mem_responder #(
    parameter int unsigned DATA_W    = mem_pkg::DATA_W,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DEPTH     = mem_pkg::MEM_DEPTH,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    import mem_pkg::*;

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_M1 = CNT_W'(WRITE_LAT - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic              req_err;
    logic [CNT_W-1:0]  lat_m1;
    logic              going_resp;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        accept  = req_valid && req_ready;
        req_err = (req_addr >> IDX_W) != '0;
        lat_m1  = req_write ? WR_M1 : RD_M1;

        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;

        unique case (state_q)
            MS_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MS_RESP;
                end
            end
            default: state_d = MS_IDLE;
        endcase

        if (accept) begin
            wr_d    = req_write;
            err_d   = req_err;
            idx_d   = req_addr[IDX_W-1:0];
            wdata_d = req_wdata;
            cnt_d   = lat_m1;
            state_d = (lat_m1 == '0) ? MS_RESP : MS_BUSY;
        end

        // state_d is MS_RESP only on the edge that enters a response, so the *_d operands
        // are either the freshly accepted request or the one already in flight.
        going_resp = (state_d == MS_RESP);
        ram_we     = rst && going_resp && wr_d && !err_d;
        ram_re     = rst && going_resp && !wr_d && !err_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    data_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (idx_d),
        .wdata_i (wdata_d),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        req_ready = (state_q != MS_BUSY);
        stall     = (state_q == MS_BUSY) || accept;
        rsp_valid = (state_q == MS_RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !wr_q && !err_q) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with READ_LAT=2, WRITE_LAT=1, DEPTH=256.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [17:0] req_addr = '0;
    logic [17:0] req_wdata = '0;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [17:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DATA_W    (18),
        .ADDR_W    (18),
        .DEPTH     (256),
        .READ_LAT  (2),
        .WRITE_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [17:0] a, input logic [17:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Samples mid-cycle, well away from the rising edge.
    task automatic expect_out(input string tag, input logic rv, input logic [17:0] rd,
                              input logic er, input logic st, input logic rdy);
        #4;
        check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
        check_eq({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(rd));
        check_eq({tag, ".rsp_err"},   32'(rsp_err),   32'(er));
        check_eq({tag, ".stall"},     32'(stall),     32'(st));
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    endtask

    initial begin
        // 1: reset held for three cycles while idle
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            expect_out("rst_idle", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        end
        next_cycle();
        drive(1'b1, 1'b0, 18'h3, 18'h0);
        expect_out("rst_stall_follows_valid", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        rst = 1'b1;
        expect_out("rst_release", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);

        // 2: store then load accepted in the store ack cycle
        next_cycle();
        drive(1'b1, 1'b1, 18'h3, 18'h2A5F5);
        expect_out("s2_store", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 18'h3, 18'h0);
        expect_out("s2_store_ack", 1'b1, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s2_load_busy", 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_out("s2_load_rsp", 1'b1, 18'h2A5F5, 1'b0, 1'b0, 1'b1);

        // 3: load held valid, back-to-back with no bubble
        next_cycle();
        drive(1'b1, 1'b0, 18'h3, 18'h0);
        expect_out("s3_acc0", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        expect_out("s3_busy0", 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_out("s3_rsp0_acc1", 1'b1, 18'h2A5F5, 1'b0, 1'b1, 1'b1);
        next_cycle();
        expect_out("s3_busy1", 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s3_rsp1", 1'b1, 18'h2A5F5, 1'b0, 1'b0, 1'b1);

        // 4: out-of-range store is dropped, no aliasing onto addr 0
        next_cycle();
        drive(1'b1, 1'b1, 18'h0, 18'h00015);
        expect_out("s4_store0", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 18'h00100, 18'h1);
        expect_out("s4_store0_ack", 1'b1, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 18'h0, 18'h0);
        expect_out("s4_oor_store_ack", 1'b1, 18'h0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s4_load0_busy", 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 18'h00100, 18'h0);
        expect_out("s4_load0_rsp", 1'b1, 18'h00015, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s4_oor_load_busy", 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_out("s4_oor_load_rsp", 1'b1, 18'h0, 1'b1, 1'b0, 1'b1);

        // 5: reset during an in-flight load
        next_cycle();
        drive(1'b1, 1'b0, 18'h3, 18'h0);
        expect_out("s5_acc", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        rst = 1'b0;
        expect_out("s5_rst0", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        expect_out("s5_rst1", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        rst = 1'b1;
        expect_out("s5_release", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        expect_out("s5_no_late_rsp", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 18'h3, 18'h0);
        expect_out("s5_reload", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s5_reload_busy", 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_out("s5_reload_rsp", 1'b1, 18'h2A5F5, 1'b0, 1'b0, 1'b1);

        // 6: store lost when reset lands before its ack edge
        next_cycle();
        drive(1'b1, 1'b1, 18'h5, 18'h03333);
        expect_out("s6_seed", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s6_seed_ack", 1'b1, 18'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b1, 18'h5, 18'h00777);
        #1;
        rst = 1'b0;
        expect_out("s6_store_in_rst", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s6_rst_hold", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        rst = 1'b1;
        expect_out("s6_release", 1'b0, 18'h0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 18'h5, 18'h0);
        expect_out("s6_load", 1'b0, 18'h0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 18'h0, 18'h0);
        expect_out("s6_load_busy", 1'b0, 18'h0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_out("s6_load_rsp", 1'b1, 18'h03333, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
